// File: rtl/adsr_envelope.sv
// adsr_envelope: per-voice ADSR envelope generator plus output gain stage.
// Ports:
//   clk, reset (sync, active-low)  - clock and reset
//   sample_tick                    - one-clk strobe, advances the envelope
//   note_in                        - gate, high while key held
//   attack/decay/rel               - per-tick level steps
//   sustain                        - sustain level (clamped to FULL)
//   amplitude                      - master volume, FULL = unity
//   wave_in                        - signed oscillator sample
//   wave_out                       - enveloped, volume-scaled sample (2 clk latency)
//   env_level, env_state, active   - envelope status
module adsr_envelope #(
    parameter int                SAMPLE_W = 32,
    parameter int                LVL_W    = 31,
    parameter logic [LVL_W-1:0]  FULL     = 31'd1073741824
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_tick,
    input  logic                       note_in,
    input  logic        [LVL_W-1:0]    attack,
    input  logic        [LVL_W-1:0]    decay,
    input  logic        [LVL_W-1:0]    sustain,
    input  logic        [LVL_W-1:0]    rel,
    input  logic        [LVL_W-1:0]    amplitude,
    input  logic signed [SAMPLE_W-1:0] wave_in,
    output logic signed [SAMPLE_W-1:0] wave_out,
    output logic        [LVL_W-1:0]    env_level,
    output logic        [2:0]          env_state,
    output logic                       active
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ATTACK  = 3'd1;
    localparam logic [2:0] S_DECAY   = 3'd2;
    localparam logic [2:0] S_SUSTAIN = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    // Fixed-point: FULL is 1.0, so products are renormalised by FRAC bits.
    localparam int FRAC = $clog2(FULL);
    localparam int IW   = LVL_W + 1;
    localparam int P1W  = SAMPLE_W + 1;
    localparam int M1W  = SAMPLE_W + LVL_W;
    localparam int M2W  = P1W + LVL_W + 1;
    localparam int S2W  = M2W - FRAC;
    localparam int HIW  = S2W - SAMPLE_W + 1;

    logic [2:0]          state_q, state_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                note_q;
    logic [P1W-1:0]      p1_q, p1_d;
    logic [SAMPLE_W-1:0] out_q, out_d;

    //----------------------------------------------------------------
    // Envelope arithmetic, one bit wider than the level so nothing wraps
    //----------------------------------------------------------------
    logic [IW-1:0] full_w;
    logic [IW-1:0] lvl_w;
    logic [IW-1:0] sus_raw;
    logic [IW-1:0] sus_w;
    logic [IW-1:0] att_w;
    logic [IW-1:0] dec_w;
    logic [IW-1:0] rel_w;
    logic [IW-1:0] sum_w;
    logic [IW-1:0] gap_w;
    logic          rise;
    logic          fall;

    assign full_w  = {1'b0, FULL};
    assign lvl_w   = {1'b0, level_q};
    assign sus_raw = {1'b0, sustain};
    assign sus_w   = (sus_raw > full_w) ? full_w : sus_raw;
    assign att_w   = {1'b0, attack};
    assign dec_w   = {1'b0, decay};
    assign rel_w   = {1'b0, rel};
    assign sum_w   = lvl_w + att_w;
    // Distance above sustain; only meaningful when lvl_w > sus_w.
    assign gap_w   = lvl_w - sus_w;

    assign rise = note_in & ~note_q;
    assign fall = ~note_in & note_q;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (rise) begin
            // Retrigger keeps the level to avoid a click.
            state_d = S_ATTACK;
        end else if (fall) begin
            if (state_q == S_ATTACK || state_q == S_DECAY ||
                state_q == S_SUSTAIN) begin
                state_d = S_RELEASE;
            end
        end else if (sample_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    level_d = '0;
                end
                S_ATTACK: begin
                    if (attack == '0 || sum_w >= full_w) begin
                        level_d = FULL;
                        state_d = S_DECAY;
                    end else begin
                        level_d = sum_w[LVL_W-1:0];
                    end
                end
                S_DECAY: begin
                    if (lvl_w <= sus_w) begin
                        level_d = sus_w[LVL_W-1:0];
                        state_d = S_SUSTAIN;
                    end else if (decay == '0) begin
                        level_d = level_q;
                    end else if (dec_w >= gap_w) begin
                        level_d = sus_w[LVL_W-1:0];
                        state_d = S_SUSTAIN;
                    end else begin
                        level_d = level_q - decay;
                    end
                end
                S_SUSTAIN: begin
                    // Track live sustain edits.
                    level_d = sus_w[LVL_W-1:0];
                end
                S_RELEASE: begin
                    if (rel == '0) begin
                        level_d = level_q;
                    end else if (rel_w >= lvl_w) begin
                        level_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        level_d = level_q - rel;
                    end
                end
                default: begin
                    level_d = '0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    //----------------------------------------------------------------
    // Gain pipeline: stage 1 applies the envelope, stage 2 the volume
    //----------------------------------------------------------------
    logic signed [M1W-1:0] m1;
    logic signed [M2W-1:0] m2;
    logic        [S2W-1:0] sh2;
    logic        [HIW-1:0] hi2;
    logic                  unused_lo;

    assign m1 = $signed({{LVL_W{wave_in[SAMPLE_W-1]}}, wave_in})
              * $signed({{SAMPLE_W{1'b0}}, level_q});
    assign p1_d = m1[FRAC+P1W-1:FRAC];

    assign m2 = $signed({{(LVL_W+1){p1_q[P1W-1]}}, p1_q})
              * $signed({{(P1W+1){1'b0}}, amplitude});
    assign sh2 = m2[M2W-1:FRAC];
    // Result fits when all bits from the output sign bit upward agree.
    assign hi2 = sh2[S2W-1:SAMPLE_W-1];

    always_comb begin
        out_d = sh2[SAMPLE_W-1:0];
        if (!((&hi2) || (~|hi2))) begin
            if (sh2[S2W-1]) begin
                out_d = {1'b1, {(SAMPLE_W-1){1'b0}}};
            end else begin
                out_d = {1'b0, {(SAMPLE_W-1){1'b1}}};
            end
        end
    end

    // Fractional bits below the renormalisation point are discarded.
    assign unused_lo = ^{m1[FRAC-1:0], m2[FRAC-1:0]};

    //----------------------------------------------------------------
    // Registers
    //----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            level_q <= '0;
            note_q  <= 1'b0;
            p1_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            note_q  <= note_in;
            p1_q    <= p1_d;
            out_q   <= out_d;
        end
    end

    assign wave_out  = out_q;
    assign env_level = level_q;
    assign env_state = state_q;
    assign active    = (state_q != S_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: directed stimulus against a behavioural ADSR model,
// every-cycle compare plus literal checks of key envelope points.
module tb_adsr_envelope;

    localparam longint FULLV = 64'sd1073741824;
    localparam longint MAXS  = 64'sd2147483647;
    localparam longint MINS  = -64'sd2147483648;

    logic               clk;
    logic               reset;
    logic               sample_tick;
    logic               note_in;
    logic        [30:0] attack;
    logic        [30:0] decay;
    logic        [30:0] sustain;
    logic        [30:0] rel;
    logic        [30:0] amplitude;
    logic signed [31:0] wave_in;
    logic signed [31:0] wave_out;
    logic        [30:0] env_level;
    logic        [2:0]  env_state;
    logic               active;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    adsr_envelope dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .note_in     (note_in),
        .attack      (attack),
        .decay       (decay),
        .sustain     (sustain),
        .rel         (rel),
        .amplitude   (amplitude),
        .wave_in     (wave_in),
        .wave_out    (wave_out),
        .env_level   (env_level),
        .env_state   (env_state),
        .active      (active)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     m_state;
    longint m_level;
    bit     m_note;
    longint m_p1;
    longint m_out;
    longint t, s, nl;
    bit     rise, fall;

    function automatic longint wrap33(input longint x);
        longint y;
        y = x & 64'h1_FFFF_FFFF;
        if (y >= 64'sh1_0000_0000) y = y - 64'sh2_0000_0000;
        return y;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_state = 0;
            m_level = 0;
            m_note  = 0;
            m_p1    = 0;
            m_out   = 0;
        end else begin
            t = (m_p1 * longint'(amplitude)) >>> 30;
            if (t > MAXS) t = MAXS;
            if (t < MINS) t = MINS;
            m_out = t;
            m_p1  = wrap33((longint'(wave_in) * m_level) >>> 30);
            rise = note_in && !m_note;
            fall = !note_in && m_note;
            s = (longint'(sustain) > FULLV) ? FULLV : longint'(sustain);
            if (rise) begin
                m_state = 1;
            end else if (fall) begin
                if (m_state >= 1 && m_state <= 3) m_state = 4;
            end else if (sample_tick) begin
                case (m_state)
                    1: begin
                        nl = m_level + longint'(attack);
                        if (attack == 0 || nl >= FULLV) begin
                            m_level = FULLV;
                            m_state = 2;
                        end else m_level = nl;
                    end
                    2: begin
                        if (m_level <= s) begin
                            m_level = s;
                            m_state = 3;
                        end else if (decay != 0) begin
                            nl = m_level - longint'(decay);
                            if (nl <= s) begin
                                m_level = s;
                                m_state = 3;
                            end else m_level = nl;
                        end
                    end
                    3: m_level = s;
                    4: begin
                        if (rel != 0) begin
                            nl = m_level - longint'(rel);
                            if (nl <= 0) begin
                                m_level = 0;
                                m_state = 0;
                            end else m_level = nl;
                        end
                    end
                    default: m_level = 0;
                endcase
            end
            m_note = note_in;
        end
    end

    // ---------------- every-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_state", longint'(env_state), longint'(m_state));
            chk("model_level", longint'(env_level), m_level);
            chk("model_active", longint'(active), longint'(m_state != 0));
            chk("model_wave", longint'(wave_out), m_out);
        end
    end

    // One clock with the given tick; called at a negedge, returns at the next.
    task automatic go(input bit tk);
        sample_tick = tk;
        @(negedge clk);
        sample_tick = 0;
    endtask

    initial begin
        reset       = 0;
        sample_tick = 0;
        note_in     = 1;
        attack      = 31'd268435456;
        decay       = 31'd0;
        sustain     = 31'd1073741824;
        rel         = 31'd0;
        amplitude   = 31'd1073741824;
        wave_in     = 32'sd1000;
        @(negedge clk);
        go(0);
        chk("rst_state", longint'(env_state), 0);
        chk("rst_level", longint'(env_level), 0);
        chk("rst_wave", longint'(wave_out), 0);
        chk("rst_active", longint'(active), 0);
        chk_en = 1;

        // Held gate seen as a rising edge after reset.
        reset = 1;
        go(0);
        chk("post_rst_attack", longint'(env_state), 1);

        go(1); chk("att1", longint'(env_level), 268435456);
        go(1); chk("att2", longint'(env_level), 536870912);
        go(1); chk("att3", longint'(env_level), 805306368);
        go(1); chk("att4", longint'(env_level), 1073741824);
        chk("att4_decay", longint'(env_state), 2);
        go(1); chk("to_sustain", longint'(env_state), 3);

        wave_in = 0;    go(0); go(0);
        wave_in = 1000; go(0); chk("lat1", longint'(wave_out), 0);
        wave_in = 0;    go(0); chk("lat2", longint'(wave_out), 1000);

        // attack=0 jump, decay to sustain, live sustain edits
        attack  = 0;
        decay   = 31'd134217728;
        sustain = 31'd805306368;
        note_in = 0; go(0);
        note_in = 1; go(0);
        go(1); chk("att0_full", longint'(env_level), 1073741824);
        chk("att0_decay", longint'(env_state), 2);
        go(1); chk("dec1", longint'(env_level), 939524096);
        go(1); chk("dec2", longint'(env_level), 805306368);
        chk("dec2_sus", longint'(env_state), 3);
        sustain = 31'd536870912; go(1);
        chk("sus_live", longint'(env_level), 536870912);
        sustain = 31'd2000000000; go(1);
        chk("sus_clamp", longint'(env_level), 1073741824);
        sustain = 31'd536870912; go(1);
        chk("sus_back", longint'(env_level), 536870912);

        // Release; gate edge and tick together leave level alone.
        rel = 31'd268435456;
        note_in = 0; go(1);
        chk("rel_edge_state", longint'(env_state), 4);
        chk("rel_edge_level", longint'(env_level), 536870912);
        go(1); chk("rel1", longint'(env_level), 268435456);
        go(1); chk("rel2", longint'(env_level), 0);
        chk("rel2_idle", longint'(env_state), 0);
        chk("rel2_active", longint'(active), 0);

        // Falling mid-attack, then retrigger mid-release.
        note_in = 1; go(0);
        attack = 31'd268435456; go(1);
        note_in = 0; go(0);
        chk("fall_att_state", longint'(env_state), 4);
        chk("fall_att_level", longint'(env_level), 268435456);
        note_in = 1; go(1);
        chk("retrig_state", longint'(env_state), 1);
        chk("retrig_level", longint'(env_level), 268435456);
        go(1); chk("retrig_up", longint'(env_level), 536870912);

        // decay==0 holds; huge decay snaps to sustain.
        attack = 0; decay = 0; go(1); go(1);
        chk("dec0_hold", longint'(env_level), 1073741824);
        chk("dec0_state", longint'(env_state), 2);
        decay = 31'h7FFFFFFF; go(1);
        chk("dec_big", longint'(env_level), 536870912);
        chk("dec_big_state", longint'(env_state), 3);

        // rel==0 holds; huge rel goes straight to idle.
        note_in = 0; go(0);
        rel = 0; go(1);
        chk("rel0_hold", longint'(env_level), 536870912);
        rel = 31'h7FFFFFFF; go(1);
        chk("rel_big", longint'(env_level), 0);
        chk("rel_big_state", longint'(env_state), 0);

        // Saturation at full envelope.
        note_in = 1; go(0);
        go(1);
        sustain = 31'd1073741824; go(1);
        chk("sat_setup", longint'(env_level), 1073741824);
        amplitude = 31'h7FFFFFFF;
        wave_in = 32'sh7FFFFFFF; go(0); go(0);
        chk("sat_pos", longint'(wave_out), 2147483647);
        wave_in = 32'sh80000000; go(0); go(0);
        chk("sat_neg", longint'(wave_out), -64'sd2147483648);
        amplitude = 31'd536870912;
        wave_in = -32'sd1000; go(0); go(0);
        chk("half_vol", longint'(wave_out), -500);
        wave_in = -32'sd1001; go(0); go(0);
        chk("half_floor", longint'(wave_out), -501);

        go(0); go(0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
